// File: rtl/pc_stack_seq_if.sv
// rtl/pc_stack_seq_if.sv - command and status bundle for the program counter / return stack
interface pc_stack_seq_if #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              en;
    logic              load;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] tgt_addr;
    logic              clr_err;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] tos;
    logic [CNT_W-1:0]  sp;
    logic              empty;
    logic              full;
    logic              ovf_err;
    logic              unf_err;

    modport master (
        output en, load, call, ret, tgt_addr, clr_err,
        input  pc_addr, tos, sp, empty, full, ovf_err, unf_err
    );

    modport slave (
        input  en, load, call, ret, tgt_addr, clr_err,
        output pc_addr, tos, sp, empty, full, ovf_err, unf_err
    );
endinterface

// File: rtl/pc_stack_seq.sv
// rtl/pc_stack_seq.sv - program counter sequencer with LIFO return-address stack
module pc_stack_seq #(
    parameter int              ADDR_W    = 13,
    parameter int              DEPTH     = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input logic           clk,
    input logic           rst,
    pc_stack_seq_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] SP_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] stack_mem [DEPTH];
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic [CNT_W-1:0]  sp_q, sp_d, sp_m1;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic              ovf_q, unf_q;
    logic              ovf_set, unf_set;
    logic              push;
    logic              is_empty, is_full;

    assign pc_inc   = pc_q + 1'b1;
    assign sp_m1    = sp_q - 1'b1;
    assign push_idx = sp_q[IDX_W-1:0];
    assign top_idx  = sp_m1[IDX_W-1:0];
    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SP_FULL);

    // Priority ret > call > load > increment; everything is gated by en.
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (bus.en) begin
            if (bus.ret) begin
                if (!is_empty) begin
                    pc_d = stack_mem[top_idx];
                    sp_d = sp_m1;
                end else begin
                    pc_d    = pc_inc;
                    unf_set = 1'b1;
                end
            end else if (bus.call) begin
                pc_d = bus.tgt_addr;
                if (!is_full) begin
                    push = 1'b1;
                    sp_d = sp_q + 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (bus.load) begin
                pc_d = bus.tgt_addr;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            // A fresh error on the clearing edge keeps the flag set.
            ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
            unf_q <= unf_set | (unf_q & ~bus.clr_err);
        end
    end

    // Storage is not cleared by reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    assign bus.pc_addr = pc_q;
    assign bus.sp      = sp_q;
    assign bus.tos     = is_empty ? '0 : stack_mem[top_idx];
    assign bus.empty   = is_empty;
    assign bus.full    = is_full;
    assign bus.ovf_err = ovf_q;
    assign bus.unf_err = unf_q;
endmodule

// File: tb/tb_pc_stack_seq.sv
// tb/tb_pc_stack_seq.sv - scoreboard bench for pc_stack_seq against a queue-based model
module tb_pc_stack_seq;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PC_MOD = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_stack_seq_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    pc_stack_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_VEC('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int pc;
        int sp;
        int tos;
        int empty;
        int full;
        int ovf;
        int unf;
    } exp_t;

    exp_t exp_q[$];
    int   m_pc;
    int   m_stk[$];
    int   m_ovf, m_unf;
    int   errors = 0;
    int   checks = 0;

    task automatic cmp(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: a plain queue as the stack, integer PC modulo 2^ADDR_W.
    task automatic model_step(input bit r, input bit e, input bit ld, input bit cl,
                              input bit rt, input int tgt, input bit clr);
        if (r) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        if (clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (!e) return;
        if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_pc  = (m_pc + 1) % PC_MOD;
                m_unf = 1;
            end
        end else if (cl) begin
            if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % PC_MOD);
            else m_ovf = 1;
            m_pc = tgt;
        end else if (ld) begin
            m_pc = tgt;
        end else begin
            m_pc = (m_pc + 1) % PC_MOD;
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit ld, input bit cl,
                         input bit rt, input int tgt, input bit clr);
        exp_t x;
        @(negedge clk);
        rst          = r;
        bus.en       = e;
        bus.load     = ld;
        bus.call     = cl;
        bus.ret      = rt;
        bus.tgt_addr = ADDR_W'(tgt);
        bus.clr_err  = clr;
        @(posedge clk);
        model_step(r, e, ld, cl, rt, tgt, clr);
        x.pc    = m_pc;
        x.sp    = m_stk.size();
        x.tos   = (m_stk.size() > 0) ? m_stk[$] : 0;
        x.empty = (m_stk.size() == 0);
        x.full  = (m_stk.size() == DEPTH);
        x.ovf   = m_ovf;
        x.unf   = m_unf;
        exp_q.push_back(x);
    endtask

    task automatic inc();                 cycle(0, 1, 0, 0, 0, 0, 0); endtask
    task automatic jmp(input int t);      cycle(0, 1, 1, 0, 0, t, 0); endtask
    task automatic sub(input int t);      cycle(0, 1, 0, 1, 0, t, 0); endtask
    task automatic rtn();                 cycle(0, 1, 0, 0, 1, 0, 0); endtask
    task automatic reset_dut();           cycle(1, 1, 1, 1, 1, 16'h0abc, 0); endtask

    // Direct checks of the spec's literal values, taken just after the edge.
    task automatic expect_now(input string name, input int pc, input int sp,
                              input int ovf, input int unf);
        #2;
        cmp({name, ".pc"}, int'(bus.pc_addr), pc);
        cmp({name, ".sp"}, int'(bus.sp), sp);
        cmp({name, ".ovf"}, int'(bus.ovf_err), ovf);
        cmp({name, ".unf"}, int'(bus.unf_err), unf);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("pc_addr", int'(bus.pc_addr), e.pc);
                cmp("sp",      int'(bus.sp),      e.sp);
                cmp("tos",     int'(bus.tos),     e.tos);
                cmp("empty",   int'(bus.empty),   e.empty);
                cmp("full",    int'(bus.full),    e.full);
                cmp("ovf_err", int'(bus.ovf_err), e.ovf);
                cmp("unf_err", int'(bus.unf_err), e.unf);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bus.en = 0; bus.load = 0; bus.call = 0; bus.ret = 0;
        bus.tgt_addr = '0; bus.clr_err = 0;
        m_pc = 0; m_ovf = 0; m_unf = 0;

        reset_dut();
        reset_dut();
        #2;
        cmp("reset.empty", int'(bus.empty), 1);
        cmp("reset.full",  int'(bus.full), 0);
        cmp("reset.tos",   int'(bus.tos), 0);
        expect_now("reset", 0, 0, 0, 0);

        for (int i = 0; i < 5; i++) inc();
        expect_now("inc5", 5, 0, 0, 0);
        jmp(13'h1fff);
        inc();
        expect_now("wrap", 0, 0, 0, 0);

        jmp(13'h0010);
        sub(13'h0100);
        #2;
        cmp("call.tos", int'(bus.tos), 13'h0011);
        expect_now("call", 13'h0100, 1, 0, 0);
        rtn();
        expect_now("ret", 13'h0011, 0, 0, 0);

        jmp(13'h0010); sub(13'h0020); sub(13'h0030); sub(13'h0040); sub(13'h0050);
        #2;
        cmp("nest.full", int'(bus.full), 1);
        sub(13'h0500);
        expect_now("ovf", 13'h0500, 4, 1, 0);
        rtn(); expect_now("pop1", 13'h0041, 3, 1, 0);
        rtn(); expect_now("pop2", 13'h0031, 2, 1, 0);
        rtn(); expect_now("pop3", 13'h0021, 1, 1, 0);
        rtn(); expect_now("pop4", 13'h0011, 0, 1, 0);

        reset_dut();
        rtn();
        expect_now("unf", 1, 0, 0, 1);
        cycle(0, 1, 0, 0, 0, 0, 1);
        expect_now("clr", 2, 0, 0, 0);
        rtn();
        cycle(0, 1, 0, 0, 1, 0, 1);
        expect_now("clr_set", 4, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        expect_now("clr_stall", 4, 0, 0, 0);

        jmp(13'h0032);
        sub(13'h0100);
        cycle(0, 1, 1, 1, 1, 13'h0777, 0);
        expect_now("prio", 13'h0033, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 13'h0999, 0);
        expect_now("stall", 13'h0033, 0, 0, 0);

        sub(13'h0200); sub(13'h0300); sub(13'h0400);
        reset_dut();
        expect_now("midrst", 0, 0, 0, 0);
        rtn();
        expect_now("midrst_unf", 1, 0, 0, 1);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 4) != 0),
                  $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  int'($urandom & 32'h1fff),
                  ($urandom_range(0, 9) == 0));
        end

        repeat (2) @(posedge clk);
        #2;
        cmp("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
